// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word widths, opcode encodings and the fetch FSM state type.
package cpu_pkg;

    localparam int unsigned INS_W  = 19;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned OPC_W  = 5;

    localparam logic [OPC_W-1:0] OP_JMP  = 5'b01101;
    localparam logic [OPC_W-1:0] OP_BEQ  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_BNE  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_CALL = 5'b10000;
    localparam logic [OPC_W-1:0] OP_RET  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11111;

    typedef enum logic [1:0] {
        StFetch    = 2'd0,
        StWaitMem  = 2'd1,
        StWaitExec = 2'd2,
        StHalted   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding program-memory reads, redirect/squash handling,
// and the one-cycle load_IR strobe that hands each accepted instruction to the IR.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned      ADDR_W  = cpu_pkg::ADDR_W,
    parameter int unsigned      INS_W   = cpu_pkg::INS_W,
    parameter logic [OPC_W-1:0] HALT_OP = OP_HALT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INS_W-1:0]  mem_rdata,
    input  logic              mem_rvalid,
    output logic [INS_W-1:0]  ins,
    output logic              load_IR,
    output logic [ADDR_W-1:0] pc,
    input  logic              fetch_next,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PcInc = ADDR_W'(1);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_pc;
    logic [INS_W-1:0]  r_ins;
    logic              r_load_ir;
    logic              r_halted;
    logic              r_squash;
    logic              w_is_halt;

    assign w_is_halt = (mem_rdata[INS_W-1 -: OPC_W] == HALT_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StFetch;
            r_fetch_pc <= '0;
            r_pc       <= '0;
            r_ins      <= '0;
            r_load_ir  <= 1'b0;
            r_halted   <= 1'b0;
            r_squash   <= 1'b0;
        end else begin
            r_load_ir <= 1'b0;
            unique case (r_state)
                StFetch: begin
                    // The request still goes out this cycle; its response is discarded later.
                    r_state <= StWaitMem;
                    if (redirect_valid) begin
                        r_fetch_pc <= redirect_addr;
                        r_squash   <= 1'b1;
                    end
                end
                StWaitMem: begin
                    if (mem_rvalid && !r_squash && !redirect_valid) begin
                        r_ins      <= mem_rdata;
                        r_pc       <= r_fetch_pc;
                        r_load_ir  <= 1'b1;
                        r_fetch_pc <= r_fetch_pc + PcInc;
                        if (w_is_halt) begin
                            r_state  <= StHalted;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= StWaitExec;
                        end
                    end else if (mem_rvalid) begin
                        r_squash <= 1'b0;
                        r_state  <= StFetch;
                        if (redirect_valid) begin
                            r_fetch_pc <= redirect_addr;
                        end
                    end else if (redirect_valid) begin
                        r_fetch_pc <= redirect_addr;
                        r_squash   <= 1'b1;
                    end
                end
                StWaitExec: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= redirect_addr;
                        r_state    <= StFetch;
                    end else if (fetch_next) begin
                        r_state <= StFetch;
                    end
                end
                StHalted: begin
                    r_state <= StHalted;
                end
                default: begin
                    r_state <= StFetch;
                end
            endcase
        end
    end

    // Gated by rst so no request is visible while reset is held.
    assign mem_req  = (r_state == StFetch) && !rst;
    assign mem_addr = r_fetch_pc;
    assign ins      = r_ins;
    assign pc       = r_pc;
    assign load_IR  = r_load_ir;
    assign halted   = r_halted;

endmodule
